// File: rtl/shift_feeder_if.sv
// Handshake and serial-output bundle for shift_feeder.
// master: upstream word source / serial consumer side; slave: the feeder itself.
interface shift_feeder_if #(
  parameter int unsigned WIDTH = 5
) ();
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_en;
  logic             busy;
  logic             done;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_en, busy, done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_en, busy, done
  );
endinterface

// File: rtl/shift_feeder.sv
// Parallel-to-serial feeder for a downstream serial shift register.
// Accepts a WIDTH-bit word on a valid/ready handshake and emits it one bit per
// DIV-clock bit-period, strobing sout_en in the first clock of each period.
// Optional feature: define SHIFT_FEEDER_PARITY_EN to append an even-parity bit
// (extra PAR bit-period, done moves to the parity strobe).
module shift_feeder #(
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned DIV       = 1,
  parameter int unsigned MSB_FIRST = 1
) (
  input logic           clk,
  input logic           rst,
  shift_feeder_if.slave bus
);

  localparam logic [4:0] LastBit = 5'(WIDTH - 1);
  localparam logic [7:0] LastDiv = 8'(DIV - 1);

`ifdef SHIFT_FEEDER_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] hold_q;   // bits still to be emitted, next one at the head
  logic [4:0]       bit_q;
  logic [7:0]       div_q;
  logic             sout_q;
  logic             sout_en_q;
  logic             busy_q;
  logic             done_q;
  logic             ready_q;
`ifdef SHIFT_FEEDER_PARITY_EN
  logic             parity_q;
`endif

  // Bit emitted first from a word, depending on bit order.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Drop the head bit so the following bit becomes the head.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  assign bus.din_ready = ready_q;
  assign bus.sout      = sout_q;
  assign bus.sout_en   = sout_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  // Control FSM with registered outputs; strobes default low every clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      sout_q    <= 1'b0;
      sout_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
`ifdef SHIFT_FEEDER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      sout_en_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.din_valid && ready_q) begin
            state_q   <= StShift;
            hold_q    <= advance(bus.din);
            sout_q    <= head(bus.din);
            sout_en_q <= 1'b1;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            bit_q     <= '0;
            div_q     <= '0;
`ifdef SHIFT_FEEDER_PARITY_EN
            parity_q  <= ^bus.din;
`else
            done_q    <= (LastBit == 5'd0);
`endif
          end
        end
        StShift: begin
          if (div_q == LastDiv) begin
            div_q <= '0;
            if (bit_q == LastBit) begin
`ifdef SHIFT_FEEDER_PARITY_EN
              state_q   <= StPar;
              sout_q    <= parity_q;
              sout_en_q <= 1'b1;
              done_q    <= 1'b1;
`else
              state_q   <= StIdle;
              sout_q    <= 1'b0;
              busy_q    <= 1'b0;
              ready_q   <= 1'b1;
              bit_q     <= '0;
`endif
            end else begin
              bit_q     <= bit_q + 5'd1;
              sout_q    <= head(hold_q);
              hold_q    <= advance(hold_q);
              sout_en_q <= 1'b1;
`ifndef SHIFT_FEEDER_PARITY_EN
              done_q    <= ((bit_q + 5'd1) == LastBit);
`endif
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
`ifdef SHIFT_FEEDER_PARITY_EN
        StPar: begin
          if (div_q == LastDiv) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_feeder.sv
// Scoreboard bench for shift_feeder: two instances (DIV=1 MSB-first, DIV=3 LSB-first).
// Stimulus pushes expected bits into per-instance queues; a negedge monitor pops on sout_en.
module tb_shift_feeder;

`ifdef SHIFT_FEEDER_PARITY_EN
  localparam int NB = 6;
  localparam logic [4:0] SrExp = 5'b01101;  // 10110 then parity 1, last five kept
`else
  localparam int NB = 5;
  localparam logic [4:0] SrExp = 5'b10110;
`endif

  typedef struct packed {
    logic sout;
    logic done;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_feeder_if #(.WIDTH(5)) ifa ();
  shift_feeder_if #(.WIDTH(5)) ifb ();

  shift_feeder #(.WIDTH(5), .DIV(1), .MSB_FIRST(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  shift_feeder #(.WIDTH(5), .DIV(3), .MSB_FIRST(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  exp_t       exp_a[$];
  exp_t       exp_b[$];
  int         checks = 0;
  int         errors = 0;
  int         str_a  = 0;
  logic [4:0] sr_a   = '0;

  function automatic logic bitof(input logic [4:0] w, input int i, input bit msb);
    if (i >= 5) return ^w;
    return msb ? w[4-i] : w[i];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // sel=0 -> instance a (MSB first), sel=1 -> instance b (LSB first)
  task automatic push(input bit sel, input logic [4:0] w, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.sout = bitof(w, i, !sel);
      e.done = (i == NB - 1);
      if (sel) exp_b.push_back(e);
      else     exp_a.push_back(e);
    end
  endtask

  // Present w at a negedge, wait (bounded) for ready, return just after the accepting edge.
  task automatic accept(input bit sel, input logic [4:0] w);
    string p;
    if (sel) p = "b"; else p = "a";
    @(negedge clk);
    if (sel) begin ifb.din = w; ifb.din_valid = 1'b1; end
    else     begin ifa.din = w; ifa.din_valid = 1'b1; end
    for (int k = 0; k < 60; k++) begin
      if ((sel ? ifb.din_ready : ifa.din_ready) === 1'b1) break;
      @(negedge clk);
    end
    chk({p, "_accept_ready"}, sel ? ifb.din_ready : ifa.din_ready, 1);
    @(posedge clk);
  endtask

  task automatic drop(input bit sel, input logic [4:0] w);
    if (sel) begin ifb.din_valid = 1'b0; ifb.din = ~w; end
    else     begin ifa.din_valid = 1'b0; ifa.din = ~w; end
  endtask

  task automatic wait_idle(input bit sel);
    string p;
    int    k;
    if (sel) p = "b"; else p = "a";
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sel && ifb.busy === 1'b0 && exp_b.size() == 0) break;
      if (!sel && ifa.busy === 1'b0 && exp_a.size() == 0) break;
    end
    chk({p, "_idle_timeout"}, (k < 100) ? 1 : 0, 1);
  endtask

  // Scoreboard monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (ifa.sout_en === 1'b1) begin
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_strobe: got strobe with sout=%b, expected none", ifa.sout);
      end else begin
        e = exp_a.pop_front();
        chk("a_sout", ifa.sout, e.sout);
        chk("a_done", ifa.done, e.done);
      end
    end else if (ifa.done === 1'b1) chk("a_done_without_strobe", ifa.done, 0);
    if (ifb.sout_en === 1'b1) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_strobe: got strobe with sout=%b, expected none", ifb.sout);
      end else begin
        e = exp_b.pop_front();
        chk("b_sout", ifb.sout, e.sout);
        chk("b_done", ifb.done, e.done);
      end
    end else if (ifb.done === 1'b1) chk("b_done_without_strobe", ifb.done, 0);
  end

  // Downstream 5-bit shift register fed by instance a.
  always @(posedge clk) begin
    if (ifa.sout_en === 1'b1) begin
      str_a <= str_a + 1;
      sr_a  <= {sr_a[3:0], ifa.sout};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int sa0;
    int busy_n;
    logic [4:0] w;

    // 1: reset with din_valid high
    rst = 1'b1;
    ifa.din = 5'b11111; ifa.din_valid = 1'b1;
    ifb.din = 5'b11111; ifb.din_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_sout", ifa.sout, 0);
    chk("rst_a_sout_en", ifa.sout_en, 0);
    chk("rst_a_busy", ifa.busy, 0);
    chk("rst_a_done", ifa.done, 0);
    chk("rst_a_ready", ifa.din_ready, 1);
    chk("rst_b_busy", ifb.busy, 0);
    chk("rst_b_ready", ifb.din_ready, 1);
    rst = 1'b0;
    ifa.din_valid = 1'b0; ifb.din_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_a_busy", ifa.busy, 0);
    chk("post_rst_b_busy", ifb.busy, 0);

    // 2: DIV=1 MSB-first 10110
    w = 5'b10110;
    push(0, w, NB);
    accept(0, w);
    for (int c = 1; c <= NB + 1; c++) begin
      @(negedge clk);
      if (c == 1) drop(0, w);
      chk("t2_sout_en", ifa.sout_en, (c <= NB) ? 1 : 0);
      chk("t2_done", ifa.done, (c == NB) ? 1 : 0);
      chk("t2_ready", ifa.din_ready, (c == NB + 1) ? 1 : 0);
      chk("t2_busy", ifa.busy, (c <= NB) ? 1 : 0);
    end
    chk("t2_downstream", sr_a, SrExp);

    // 3: DIV=3 LSB-first 00011
    w = 5'b00011;
    busy_n = 0;
    push(1, w, NB);
    accept(1, w);
    for (int c = 1; c <= NB * 3 + 1; c++) begin
      @(negedge clk);
      if (c == 1) drop(1, w);
      if (ifb.busy === 1'b1) busy_n++;
      chk("t3_sout_en", ifb.sout_en, (((c - 1) % 3 == 0) && c <= NB * 3) ? 1 : 0);
      chk("t3_sout", ifb.sout, (c <= NB * 3) ? bitof(w, (c - 1) / 3, 0) : 0);
      chk("t3_done", ifb.done, (c == (NB - 1) * 3 + 1) ? 1 : 0);
    end
    chk("t3_busy_cycles", busy_n, NB * 3);

    // 4: back-to-back 11111 then 00000 with din_valid held
    sa0 = str_a;
    push(0, 5'b11111, NB);
    accept(0, 5'b11111);
    for (int c = 1; c <= NB + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        ifa.din = 5'b00000;
        push(0, 5'b00000, NB);
      end
      chk("t4_ready_timing", ifa.din_ready, (c == NB + 1) ? 1 : 0);
    end
    @(posedge clk);
    @(negedge clk);
    ifa.din_valid = 1'b0;
    chk("t4_second_accepted", ifa.busy, 1);
    repeat (NB + 1) @(negedge clk);
    chk("t4_strobes", str_a - sa0, 2 * NB);
    chk("t4_queue_empty", exp_a.size(), 0);

    // 5: reset during the word, then a clean word
    w = 5'b10101;
    push(0, w, 3);
    accept(0, w);
    @(negedge clk);
    drop(0, w);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_sout", ifa.sout, 0);
    chk("t5_rst_sout_en", ifa.sout_en, 0);
    chk("t5_rst_busy", ifa.busy, 0);
    chk("t5_rst_done", ifa.done, 0);
    chk("t5_rst_ready", ifa.din_ready, 1);
    chk("t5_aborted_queue", exp_a.size(), 0);
    rst = 1'b0;
    w = 5'b01100;
    push(0, w, NB);
    accept(0, w);
    @(negedge clk);
    drop(0, w);
    wait_idle(0);

`ifdef SHIFT_FEEDER_PARITY_EN
    // 6: parity of 11110 is 0 (10110 parity 1 was covered in test 2)
    w = 5'b11110;
    push(0, w, NB);
    accept(0, w);
    @(negedge clk);
    drop(0, w);
    wait_idle(0);
`endif

    repeat (4) @(negedge clk);
    chk("final_queue_a", exp_a.size(), 0);
    chk("final_queue_b", exp_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
